// File: rtl/win_pkg.sv
// Shared constants and types for the window-multiplier sequencer (win_seq).
package win_pkg;
    localparam int Dwidth  = 16;
    localparam int Nwin    = 32;
    localparam int Iwidth  = $clog2(Nwin);
    localparam int WIN_LAT = 3;
    localparam int FDEPTH  = 8;
    localparam int CWIDTH  = 16;

    typedef struct packed {
        logic [Dwidth-1:0] re;
        logic [Dwidth-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic  last;
        cplx_t data;
    } fifo_word_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} win_seq_state_t;
endpackage

// File: rtl/win_seq_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module win_seq_fifo
    import win_pkg::*;
#(
    parameter int DEPTH = FDEPTH,
    parameter int W     = 2*Dwidth+1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/win_seq.sv
// Sequencer for the 32-point window multiplier: frame/index counting, last-tag
// realignment and a credit-managed output FIFO so downstream stalls never lose data.
module win_seq
    import win_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CWIDTH-1:0] nframes,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [CWIDTH-1:0] frame_cnt,
    output logic              ovf_err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [Dwidth-1:0] s_real,
    input  logic [Dwidth-1:0] s_imag,
    output logic              win_dv_in,
    output logic [Iwidth-1:0] win_index,
    output logic [Dwidth-1:0] win_din_real,
    output logic [Dwidth-1:0] win_din_imag,
    input  logic              win_dv_out,
    input  logic [Dwidth-1:0] win_dout_real,
    input  logic [Dwidth-1:0] win_dout_imag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [Dwidth-1:0] m_real,
    output logic [Dwidth-1:0] m_imag,
    output logic              m_last
);
    localparam int AW  = $clog2(FDEPTH);
    localparam int IFW = $clog2(WIN_LAT+2);
    localparam int IGW = $clog2(WIN_LAT+1);

    win_seq_state_t    state_q, state_d;
    logic [Iwidth-1:0] index_q, index_d;
    logic [CWIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CWIDTH-1:0] nframes_q, nframes_d;
    logic              stop_req_q, stop_req_d;
    logic [IFW-1:0]    inflight_q, inflight_d;
    logic              dv_in_q, dv_in_d;
    logic [Iwidth-1:0] win_index_q, win_index_d;
    cplx_t             din_q, din_d;
    logic [WIN_LAT:0]  tag_q, tag_d;
    logic              ovf_q, ovf_d;
    logic [IGW-1:0]    ignore_q, ignore_d;

    fifo_word_t        fifo_in, fifo_head;
    logic [AW:0]       fifo_count;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AW+1:0]     credit_used;
    logic              transfer, dv_out_ok, idx_last, run_end, done_pulse;

    // Credits cover samples still inside win plus words already in the FIFO.
    assign credit_used = (AW+2)'(inflight_q) + (AW+2)'(fifo_count);
    assign s_ready     = (state_q == RUN) && (credit_used < (AW+2)'(FDEPTH));
    assign transfer    = s_valid && s_ready;
    assign dv_out_ok   = win_dv_out && (ignore_q == '0);
    assign idx_last    = (index_q == Iwidth'(Nwin-1));
    assign run_end     = ((nframes_q != '0) && (frame_cnt_q + CWIDTH'(1) == nframes_q)) || stop_req_q;

    assign fifo_in   = '{last: tag_q[WIN_LAT], data: '{re: win_dout_real, im: win_dout_imag}};
    assign fifo_push = dv_out_ok;
    assign fifo_pop  = m_valid && m_ready;

    win_seq_fifo #(.DEPTH(FDEPTH), .W(2*Dwidth+1)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        frame_cnt_d = frame_cnt_q;
        nframes_d   = nframes_q;
        stop_req_d  = stop_req_q;
        inflight_d  = inflight_q;
        dv_in_d     = transfer;
        win_index_d = win_index_q;
        din_d       = din_q;
        tag_d       = {tag_q[WIN_LAT-1:0], transfer && idx_last};
        ovf_d       = ovf_q || (fifo_push && fifo_full && !fifo_pop);
        ignore_d    = (ignore_q != '0) ? ignore_q - IGW'(1) : ignore_q;
        done_pulse  = 1'b0;

        if (transfer) begin
            win_index_d = index_q;
            din_d       = '{re: s_real, im: s_imag};
            index_d     = idx_last ? '0 : index_q + Iwidth'(1);
            if (idx_last) begin
                frame_cnt_d = frame_cnt_q + CWIDTH'(1);
            end
        end

        case ({transfer, dv_out_ok})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = (inflight_q != '0) ? inflight_q - IFW'(1) : inflight_q;
            default: inflight_d = inflight_q;
        endcase

        // A run only ends on a frame boundary, so frames are never truncated.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    nframes_d   = nframes;
                    frame_cnt_d = '0;
                    stop_req_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_req_d = 1'b1;
                end
                if (transfer && idx_last && run_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && fifo_empty) begin
                    state_d    = IDLE;
                    done_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The ignore window swallows dv_out pulses win still emits after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            frame_cnt_q <= '0;
            nframes_q   <= '0;
            stop_req_q  <= 1'b0;
            inflight_q  <= '0;
            dv_in_q     <= 1'b0;
            win_index_q <= '0;
            din_q       <= '0;
            tag_q       <= '0;
            ovf_q       <= 1'b0;
            ignore_q    <= IGW'(WIN_LAT);
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            frame_cnt_q <= frame_cnt_d;
            nframes_q   <= nframes_d;
            stop_req_q  <= stop_req_d;
            inflight_q  <= inflight_d;
            dv_in_q     <= dv_in_d;
            win_index_q <= win_index_d;
            din_q       <= din_d;
            tag_q       <= tag_d;
            ovf_q       <= ovf_d;
            ignore_q    <= ignore_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_pulse;
    assign frame_cnt    = frame_cnt_q;
    assign ovf_err      = ovf_q;
    assign win_dv_in    = dv_in_q;
    assign win_index    = win_index_q;
    assign win_din_real = din_q.re;
    assign win_din_imag = din_q.im;
    assign m_valid      = !fifo_empty;
    assign m_real       = fifo_head.data.re;
    assign m_imag       = fifo_head.data.im;
    assign m_last       = fifo_head.last && !fifo_empty;
endmodule
